// File: rtl/branch_resolver.sv
// branch_resolver: resolution end of the branch-prediction loop.
// Holds 1-bit predictions in a FIFO until execution resolves them, returns the
// actual outcome as the predictor update, and raises mispredict/flush toward fetch.
// Optional statistics counters are built only when BRANCH_RESOLVER_STATS_EN is defined;
// otherwise br_cnt and miss_cnt are tied to zero.
module branch_resolver #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic             predict,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             taken,
  output logic             upd_valid,
  output logic             mispredict,
  output logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_TRACK,
    ST_FLUSH
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [FW-1:0] flush_cnt;
  logic [FW-1:0] flush_cnt_nxt;

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr_nxt;
  logic [AW:0]   rd_ptr_nxt;
  logic [AW:0]   occ;
  logic          mem [DEPTH];

  logic          head;
  logic          pop;
  logic          push;
  logic          miss_now;

  // Pointer-derived status; the extra MSB separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign occ   = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];
  assign flush = (state == ST_FLUSH);

  // A pop makes room, so a push into a full FIFO is allowed in the same cycle.
  // A miss discards the same-cycle push: it is on the wrong path.
  always_comb begin
    pop      = res_valid && !empty && (state != ST_FLUSH);
    miss_now = pop && (head ^ res_taken);
    push     = br_valid && (!full || pop) && (state != ST_FLUSH) && !miss_now;
  end

  // Next pointer values; a mispredict empties the whole FIFO.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (miss_now) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + (AW+1)'(1);
    end
  end

  // Next-state logic; the flush down-counter is loaded on entry to ST_FLUSH.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      ST_EMPTY: begin
        if (push) state_nxt = ST_TRACK;
      end
      ST_TRACK: begin
        if (miss_now) begin
          state_nxt     = ST_FLUSH;
          flush_cnt_nxt = FW'(FLUSH_CYC - 1);
        end else if (pop && !push && (occ == (AW+1)'(1))) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == '0) state_nxt = ST_EMPTY;
        else                 flush_cnt_nxt = flush_cnt - FW'(1);
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // State, flush counter and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      flush_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
    end
  end

  // Prediction storage; contents are don't-care while the pointers mark them empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= predict;
  end

  // Registered predictor update, one clock after the resolving res_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      upd_valid  <= 1'b0;
      taken      <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      upd_valid  <= pop;
      mispredict <= miss_now;
      if (pop) taken <= res_taken;
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  // Saturating resolve and miss counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (pop && (br_cnt_q != '1))        br_cnt_q   <= br_cnt_q + CNT_W'(1);
      if (miss_now && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign br_cnt   = '0;
  assign miss_cnt = '0;
`endif

  // Structural invariants of the FIFO/FSM pairing.
  a_full_not_empty: assert property (@(posedge clk) disable iff (!reset)
    !(full && empty));
  a_flush_is_empty: assert property (@(posedge clk) disable iff (!reset)
    (state == ST_FLUSH) |-> empty);
  a_occ_bound: assert property (@(posedge clk) disable iff (!reset)
    occ <= (AW+1)'(DEPTH));
  a_empty_state: assert property (@(posedge clk) disable iff (!reset)
    (state == ST_EMPTY) |-> empty);

endmodule
